// File: rtl/irq_trap_unit_pkg.sv
// Shared types and helpers for the interrupt trap unit: FSM state encoding,
// mcause interrupt-bit position and the cause-id width.
package irq_trap_unit_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      SERVICE = 1'b1
   } trap_state_e;

   function automatic int mcause_irq_bit(input int xlen);
      return xlen - 1;
   endfunction

   // A single channel still needs a one-bit id field.
   function automatic int cause_id_width(input int num_irq);
      int w;
      w = $clog2(num_irq);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/irq_trap_unit_priority_encoder.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module irq_priority_encoder
   import irq_trap_unit_pkg::*;
#(
   parameter int NUM_IRQ = 4,
   parameter int ID_W    = cause_id_width(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic               valid_o,
   output logic [ID_W-1:0]    id_o
);

   // Scan from the top down so the lowest active index is the last one written.
   always_comb begin
      valid_o = |req_i;
      id_o    = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         id_o = req_i[i] ? ID_W'(i) : id_o;
      end
   end

endmodule

// File: rtl/irq_trap_unit.sv
// Interrupt pending/priority/trap-entry unit with a non-nesting IDLE/SERVICE FSM.
// Optional macro TRAP_VECTORED_EN selects vectored trap targets (base + 4*id).
module irq_trap_unit
   import irq_trap_unit_pkg::*;
#(
   parameter int                 NUM_IRQ   = 4,
   parameter int                 XLEN      = 32,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irqBus,
   input  logic [NUM_IRQ-1:0] irqEnable,
   input  logic               globalEnable,
   input  logic               retire,
   input  logic               mret,
   input  logic [XLEN-1:0]    nextPC,
   input  logic [XLEN-1:0]    mtvec,
   output logic               trap,
   output logic [XLEN-1:0]    trapTarget,
   output logic [XLEN-1:0]    mepcDi,
   output logic [XLEN-1:0]    mcauseDi,
   output logic [NUM_IRQ-1:0] pending,
   output logic               inService
);

   localparam int ID_W    = cause_id_width(NUM_IRQ);
   localparam int IRQ_BIT = mcause_irq_bit(XLEN);

   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] pending_d;
   logic [NUM_IRQ-1:0] hist_q;
   logic [NUM_IRQ-1:0] rise_s;
   logic [NUM_IRQ-1:0] take_s;
   logic [NUM_IRQ-1:0] req_s;
   logic               win_valid_s;
   logic [ID_W-1:0]    win_id_s;
   logic [ID_W-1:0]    id_q;
   logic [ID_W-1:0]    cause_id_s;
   logic [XLEN-1:0]    base_s;
   logic               in_service_q;
   trap_state_e        state_q;

   assign req_s = pending_q & irqEnable;

   irq_priority_encoder #(
      .NUM_IRQ (NUM_IRQ),
      .ID_W    (ID_W)
   ) u_prio (
      .req_i   (req_s),
      .valid_o (win_valid_s),
      .id_o    (win_id_s)
   );

   assign trap   = (state_q == IDLE) & globalEnable & retire & win_valid_s & ~reset;
   assign rise_s = irqBus & ~hist_q;

   // One-hot clear of the channel being taken this cycle.
   always_comb begin
      if (trap) begin
         take_s = NUM_IRQ'(1) << win_id_s;
      end else begin
         take_s = '0;
      end
   end

   // Edge channels latch rises and clear on take (a new rise wins); level channels follow the line.
   assign pending_d = (EDGE_MASK & (rise_s | (pending_q & ~take_s))) | (~EDGE_MASK & irqBus);

   // Pending and edge-history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         hist_q    <= '0;
      end else begin
         pending_q <= pending_d;
         hist_q    <= irqBus;
      end
   end

   // Trap FSM: enter SERVICE after a trap, leave on a retiring mret.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         id_q         <= '0;
         in_service_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trap) begin
                  state_q      <= SERVICE;
                  id_q         <= win_id_s;
                  in_service_q <= 1'b1;
               end
            end
            SERVICE: begin
               if (retire && mret) begin
                  state_q      <= IDLE;
                  in_service_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               in_service_q <= 1'b0;
            end
         endcase
      end
   end

   // The trap cycle reports the live winner; during a handler the latched id.
   assign cause_id_s = (state_q == IDLE) ? win_id_s : id_q;
   assign base_s     = mtvec & {{(XLEN-2){1'b1}}, 2'b00};

   // Cause value: interrupt flag in the MSB, zero-extended channel id below.
   always_comb begin
      mcauseDi               = '0;
      mcauseDi[IRQ_BIT]      = 1'b1;
      mcauseDi[ID_W-1:0]     = cause_id_s;
   end

`ifdef TRAP_VECTORED_EN
   assign trapTarget = base_s + (XLEN'(cause_id_s) << 2);
`else
   assign trapTarget = base_s;
`endif

   assign mepcDi    = nextPC;
   assign pending   = pending_q;
   assign inService = in_service_q;

endmodule
